// File: rtl/mem_stage_pkg.sv
// Shared types and constants for the memory stage: op-field layout, access sizes,
// FSM encoding and the alignment/byte-lane helpers used by the top level.
package mem_stage_pkg;

  localparam int XLEN    = 64;
  localparam int REG_BUS = XLEN;

  typedef logic [REG_BUS-1:0] reg_bus_t;

  localparam reg_bus_t ZERO_WORD = '0;

  localparam int OP_STORE    = 3;
  localparam int OP_UNSIGNED = 2;

  localparam logic [1:0] SZ_B = 2'd0;
  localparam logic [1:0] SZ_H = 2'd1;
  localparam logic [1:0] SZ_W = 2'd2;
  localparam logic [1:0] SZ_D = 2'd3;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } state_t;

  function automatic logic is_aligned(input logic [1:0] size, input logic [2:0] off);
    logic res;
    res = 1'b1;
    case (size)
      SZ_B:    res = 1'b1;
      SZ_H:    res = (off[0] == 1'b0);
      SZ_W:    res = (off[1:0] == 2'b00);
      default: res = (off == 3'b000);
    endcase
    return res;
  endfunction

  // Size-wide run of strobes moved up to the addressed byte lane.
  function automatic logic [7:0] lane_mask(input logic [1:0] size, input logic [2:0] off);
    logic [7:0] base;
    base = 8'h00;
    case (size)
      SZ_B:    base = 8'h01;
      SZ_H:    base = 8'h03;
      SZ_W:    base = 8'h0F;
      default: base = 8'hFF;
    endcase
    return base << off;
  endfunction

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data extraction: select the addressed bytes from a read doubleword,
// then zero- or sign-extend them to the full register width.
module load_align
  import mem_stage_pkg::*;
(
  input  logic [63:0] rdata_i,
  input  logic [2:0]  off_i,
  input  logic [1:0]  size_i,
  input  logic        unsigned_i,
  output logic [63:0] result_o
);

  logic [63:0] w_shifted;

  assign w_shifted = rdata_i >> {off_i, 3'b000};

  always_comb begin
    result_o = w_shifted;
    case (size_i)
      SZ_B:    result_o = unsigned_i ? {56'h0, w_shifted[7:0]}
                                     : {{56{w_shifted[7]}}, w_shifted[7:0]};
      SZ_H:    result_o = unsigned_i ? {48'h0, w_shifted[15:0]}
                                     : {{48{w_shifted[15]}}, w_shifted[15:0]};
      SZ_W:    result_o = unsigned_i ? {32'h0, w_shifted[31:0]}
                                     : {{32{w_shifted[31]}}, w_shifted[31:0]};
      default: result_o = w_shifted;
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// Memory stage: passes ALU results through, flags misaligned accesses, and runs
// aligned loads/stores as single bus transactions while stalling upstream.
module mem_stage
  import mem_stage_pkg::*;
#(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            ex_valid_i,
  input  logic            mem_en_i,
  input  logic [3:0]      mem_op_i,
  input  logic [XLEN-1:0] ex_result_i,
  input  logic [XLEN-1:0] store_data_i,
  input  logic [4:0]      rd_addr_i,
  input  logic            rd_wen_i,
  output logic            stall_o,
  output logic            dmem_req_o,
  output logic            dmem_we_o,
  output logic [XLEN-1:0] dmem_addr_o,
  output logic [XLEN-1:0] dmem_wdata_o,
  output logic [7:0]      dmem_wmask_o,
  input  logic            dmem_ack_i,
  input  logic [XLEN-1:0] dmem_rdata_i,
  output logic            wb_valid_o,
  output logic [4:0]      wb_rd_addr_o,
  output logic            wb_rd_wen_o,
  output logic [XLEN-1:0] wb_rd_data_o,
  output logic            misalign_o
);

  state_t      r_state;
  logic [3:0]  r_op;
  logic [2:0]  r_off;
  logic [4:0]  r_rd_addr;
  logic        r_rd_wen;

  logic            w_aligned;
  logic            w_issue;
  logic [7:0]      w_wmask;
  logic [XLEN-1:0] w_wdata;
  logic [63:0]     w_load_data;

  assign w_aligned = is_aligned(mem_op_i[1:0], ex_result_i[2:0]);
  assign w_issue   = ex_valid_i & mem_en_i & w_aligned;

  // Stall covers the issue cycle and every bus cycle up to, not including, the ack.
  assign stall_o = !rst & (((r_state == ST_IDLE) & w_issue) |
                           ((r_state == ST_BUSY) & !dmem_ack_i));

  assign w_wmask = mem_op_i[OP_STORE] ? lane_mask(mem_op_i[1:0], ex_result_i[2:0]) : 8'h00;
  assign w_wdata = mem_op_i[OP_STORE] ? (store_data_i << {ex_result_i[2:0], 3'b000}) : ZERO_WORD;

  load_align u_load_align (
    .rdata_i    (dmem_rdata_i),
    .off_i      (r_off),
    .size_i     (r_op[1:0]),
    .unsigned_i (r_op[OP_UNSIGNED]),
    .result_o   (w_load_data)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= ST_IDLE;
      r_op         <= 4'h0;
      r_off        <= 3'h0;
      r_rd_addr    <= 5'h0;
      r_rd_wen     <= 1'b0;
      dmem_req_o   <= 1'b0;
      dmem_we_o    <= 1'b0;
      dmem_addr_o  <= ZERO_WORD;
      dmem_wdata_o <= ZERO_WORD;
      dmem_wmask_o <= 8'h00;
      wb_valid_o   <= 1'b0;
      wb_rd_addr_o <= 5'h0;
      wb_rd_wen_o  <= 1'b0;
      wb_rd_data_o <= ZERO_WORD;
      misalign_o   <= 1'b0;
    end else begin
      wb_valid_o <= 1'b0;
      misalign_o <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (ex_valid_i && !mem_en_i) begin
            wb_valid_o   <= 1'b1;
            wb_rd_addr_o <= rd_addr_i;
            wb_rd_wen_o  <= rd_wen_i;
            wb_rd_data_o <= ex_result_i;
          end else if (ex_valid_i && !w_aligned) begin
            wb_valid_o   <= 1'b1;
            misalign_o   <= 1'b1;
            wb_rd_addr_o <= rd_addr_i;
            wb_rd_wen_o  <= 1'b0;
            wb_rd_data_o <= ZERO_WORD;
          end else if (w_issue) begin
            r_state      <= ST_BUSY;
            r_op         <= mem_op_i;
            r_off        <= ex_result_i[2:0];
            r_rd_addr    <= rd_addr_i;
            r_rd_wen     <= rd_wen_i;
            dmem_req_o   <= 1'b1;
            dmem_we_o    <= mem_op_i[OP_STORE];
            dmem_addr_o  <= {ex_result_i[XLEN-1:3], 3'b000};
            dmem_wdata_o <= w_wdata;
            dmem_wmask_o <= w_wmask;
          end
        end
        ST_BUSY: begin
          if (dmem_ack_i) begin
            r_state      <= ST_IDLE;
            dmem_req_o   <= 1'b0;
            dmem_we_o    <= 1'b0;
            wb_valid_o   <= 1'b1;
            wb_rd_addr_o <= r_rd_addr;
            if (r_op[OP_STORE]) begin
              wb_rd_wen_o  <= 1'b0;
              wb_rd_data_o <= ZERO_WORD;
            end else begin
              wb_rd_wen_o  <= r_rd_wen;
              wb_rd_data_o <= w_load_data;
            end
          end
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: writeback expectations are queued when an op is
// driven and popped by a monitor whenever wb_valid_o pulses.
module tb_mem_stage;

  typedef struct packed {
    logic [4:0]  rd;
    logic        wen;
    logic [63:0] data;
    logic        mis;
  } exp_t;

  logic        clk;
  logic        rst;
  logic        ex_valid_i;
  logic        mem_en_i;
  logic [3:0]  mem_op_i;
  logic [63:0] ex_result_i;
  logic [63:0] store_data_i;
  logic [4:0]  rd_addr_i;
  logic        rd_wen_i;
  logic        stall_o;
  logic        dmem_req_o;
  logic        dmem_we_o;
  logic [63:0] dmem_addr_o;
  logic [63:0] dmem_wdata_o;
  logic [7:0]  dmem_wmask_o;
  logic        dmem_ack_i;
  logic [63:0] dmem_rdata_i;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_addr_o;
  logic        wb_rd_wen_o;
  logic [63:0] wb_rd_data_o;
  logic        misalign_o;

  int   total = 0;
  int   bad   = 0;
  exp_t sb_q[$];
  exp_t mon_e;
  int   stall_cnt;

  mem_stage #(.XLEN(64)) dut (
    .clk          (clk),
    .rst          (rst),
    .ex_valid_i   (ex_valid_i),
    .mem_en_i     (mem_en_i),
    .mem_op_i     (mem_op_i),
    .ex_result_i  (ex_result_i),
    .store_data_i (store_data_i),
    .rd_addr_i    (rd_addr_i),
    .rd_wen_i     (rd_wen_i),
    .stall_o      (stall_o),
    .dmem_req_o   (dmem_req_o),
    .dmem_we_o    (dmem_we_o),
    .dmem_addr_o  (dmem_addr_o),
    .dmem_wdata_o (dmem_wdata_o),
    .dmem_wmask_o (dmem_wmask_o),
    .dmem_ack_i   (dmem_ack_i),
    .dmem_rdata_i (dmem_rdata_i),
    .wb_valid_o   (wb_valid_o),
    .wb_rd_addr_o (wb_rd_addr_o),
    .wb_rd_wen_o  (wb_rd_wen_o),
    .wb_rd_data_o (wb_rd_data_o),
    .misalign_o   (misalign_o)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Writeback monitor: every pulse must match the oldest queued expectation.
  always @(negedge clk) begin
    if (wb_valid_o === 1'b1) begin
      if (sb_q.size() == 0) begin
        chk("wb_unexpected", 64'(wb_valid_o), 64'h0);
      end else begin
        mon_e = sb_q.pop_front();
        chk("wb_rd_addr", 64'(wb_rd_addr_o), 64'(mon_e.rd));
        chk("wb_rd_wen",  64'(wb_rd_wen_o),  64'(mon_e.wen));
        chk("wb_rd_data", wb_rd_data_o,      mon_e.data);
        chk("wb_misalign", 64'(misalign_o),  64'(mon_e.mis));
      end
    end else if (wb_valid_o === 1'b0 && rst === 1'b0) begin
      chk("misalign_idle", 64'(misalign_o), 64'h0);
    end
  end

  task automatic alu_op(input logic [63:0] res, input logic [4:0] rd, input logic wen);
    ex_valid_i = 1'b1; mem_en_i = 1'b0; mem_op_i = 4'h0;
    ex_result_i = res; rd_addr_i = rd; rd_wen_i = wen;
    #1;
    chk("alu_stall", 64'(stall_o), 64'h0);
    sb_q.push_back('{rd: rd, wen: wen, data: res, mis: 1'b0});
    tick();
    ex_valid_i = 1'b0;
  endtask

  task automatic misaligned_op(input logic [3:0] op, input logic [63:0] addr, input logic [4:0] rd);
    ex_valid_i = 1'b1; mem_en_i = 1'b1; mem_op_i = op;
    ex_result_i = addr; store_data_i = 64'hFFFF_FFFF_FFFF_FFFF; rd_addr_i = rd; rd_wen_i = !op[3];
    #1;
    chk("mis_stall", 64'(stall_o), 64'h0);
    sb_q.push_back('{rd: rd, wen: 1'b0, data: 64'h0, mis: 1'b1});
    tick();
    ex_valid_i = 1'b0; mem_en_i = 1'b0;
    chk("mis_no_req", 64'(dmem_req_o), 64'h0);
    tick();
    chk("mis_no_req_after", 64'(dmem_req_o), 64'h0);
  endtask

  task automatic mem_op(input string tag, input logic [3:0] op, input logic [63:0] addr,
                        input logic [63:0] sdata, input logic [4:0] rd, input int waits,
                        input logic [63:0] rdata, input logic [7:0] exp_mask,
                        input logic [63:0] exp_wdata, input logic [63:0] exp_load,
                        output int stalls);
    logic [63:0] exp_addr;
    exp_addr = {addr[63:3], 3'b000};
    ex_valid_i = 1'b1; mem_en_i = 1'b1; mem_op_i = op;
    ex_result_i = addr; store_data_i = sdata; rd_addr_i = rd; rd_wen_i = !op[3];
    #1;
    chk({tag, "_issue_stall"}, 64'(stall_o), 64'h1);
    stalls = 1;
    if (op[3]) sb_q.push_back('{rd: rd, wen: 1'b0, data: 64'h0, mis: 1'b0});
    else       sb_q.push_back('{rd: rd, wen: 1'b1, data: exp_load, mis: 1'b0});
    tick();
    for (int i = 0; i < waits; i++) begin
      chk({tag, "_req"},   64'(dmem_req_o), 64'h1);
      chk({tag, "_we"},    64'(dmem_we_o),  64'(op[3]));
      chk({tag, "_addr"},  dmem_addr_o,     exp_addr);
      chk({tag, "_wmask"}, 64'(dmem_wmask_o), 64'(exp_mask));
      chk({tag, "_wdata"}, dmem_wdata_o,    exp_wdata);
      chk({tag, "_stall"}, 64'(stall_o),    64'h1);
      if (stall_o === 1'b1) stalls++;
      tick();
    end
    dmem_ack_i = 1'b1; dmem_rdata_i = rdata;
    #1;
    chk({tag, "_ack_stall"}, 64'(stall_o), 64'h0);
    chk({tag, "_ack_req"},   64'(dmem_req_o), 64'h1);
    tick();
    dmem_ack_i = 1'b0; dmem_rdata_i = 64'h0; ex_valid_i = 1'b0; mem_en_i = 1'b0;
    chk({tag, "_req_done"}, 64'(dmem_req_o), 64'h0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst = 1'b1; ex_valid_i = 1'b0; mem_en_i = 1'b0; mem_op_i = 4'h0;
    ex_result_i = 64'h0; store_data_i = 64'h0; rd_addr_i = 5'h0; rd_wen_i = 1'b0;
    dmem_ack_i = 1'b0; dmem_rdata_i = 64'h0;
    repeat (3) tick();
    chk("rst_stall",    64'(stall_o),      64'h0);
    chk("rst_req",      64'(dmem_req_o),   64'h0);
    chk("rst_we",       64'(dmem_we_o),    64'h0);
    chk("rst_wb_valid", 64'(wb_valid_o),   64'h0);
    chk("rst_wb_wen",   64'(wb_rd_wen_o),  64'h0);
    chk("rst_misalign", 64'(misalign_o),   64'h0);
    chk("rst_addr",     dmem_addr_o,       64'h0);
    chk("rst_wmask",    64'(dmem_wmask_o), 64'h0);
    chk("rst_wb_data",  wb_rd_data_o,      64'h0);
    rst = 1'b0;
    tick();

    alu_op(64'h1234, 5'd5, 1'b1);
    alu_op(64'hCAFE_0000_0000_0001, 5'd31, 1'b0);
    tick();

    mem_op("lb",  4'b0000, 64'h1003, 64'h0, 5'd7, 1, 64'h0000_0000_8000_0000,
           8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_FF80, stall_cnt);
    mem_op("lbu", 4'b0100, 64'h1003, 64'h0, 5'd8, 0, 64'h0000_0000_8000_0000,
           8'h00, 64'h0, 64'h0000_0000_0000_0080, stall_cnt);
    mem_op("sh",  4'b1001, 64'h2002, 64'hBEEF, 5'd0, 3, 64'h0,
           8'h0C, 64'h0000_0000_BEEF_0000, 64'h0, stall_cnt);
    chk("sh_stall_cycles", 64'(stall_cnt), 64'd4);
    mem_op("lh",  4'b0001, 64'h1006, 64'h0, 5'd9, 2, 64'h8001_0000_0000_0000,
           8'h00, 64'h0, 64'hFFFF_FFFF_FFFF_8001, stall_cnt);
    mem_op("lw",  4'b0010, 64'h1004, 64'h0, 5'd10, 1, 64'hDEAD_BEEF_0000_0000,
           8'h00, 64'h0, 64'hFFFF_FFFF_DEAD_BEEF, stall_cnt);
    mem_op("lwu", 4'b0110, 64'h1004, 64'h0, 5'd11, 1, 64'hDEAD_BEEF_0000_0000,
           8'h00, 64'h0, 64'h0000_0000_DEAD_BEEF, stall_cnt);
    mem_op("ld",  4'b0111, 64'h3000, 64'h0, 5'd12, 1, 64'h0123_4567_89AB_CDEF,
           8'h00, 64'h0, 64'h0123_4567_89AB_CDEF, stall_cnt);
    mem_op("sd",  4'b1011, 64'h4000, 64'h1122_3344_5566_7788, 5'd0, 2, 64'h0,
           8'hFF, 64'h1122_3344_5566_7788, 64'h0, stall_cnt);
    mem_op("sb",  4'b1000, 64'h4007, 64'h0000_0000_0000_00AB, 5'd0, 1, 64'h0,
           8'h80, 64'hAB00_0000_0000_0000, 64'h0, stall_cnt);
    tick();

    misaligned_op(4'b0010, 64'h1002, 5'd13);
    misaligned_op(4'b1011, 64'h4004, 5'd0);
    misaligned_op(4'b0001, 64'h2001, 5'd14);

    dmem_ack_i = 1'b1; dmem_rdata_i = 64'h5555_AAAA_5555_AAAA;
    tick();
    dmem_ack_i = 1'b0; dmem_rdata_i = 64'h0;
    chk("idle_ack_wb", 64'(wb_valid_o), 64'h0);
    chk("idle_ack_req", 64'(dmem_req_o), 64'h0);
    tick();

    ex_valid_i = 1'b1; mem_en_i = 1'b1; mem_op_i = 4'b0011;
    ex_result_i = 64'h3000; rd_addr_i = 5'd15; rd_wen_i = 1'b1;
    tick();
    chk("rstbusy_req", 64'(dmem_req_o), 64'h1);
    rst = 1'b1;
    #1;
    chk("rstbusy_stall_in_rst", 64'(stall_o), 64'h0);
    tick();
    rst = 1'b0; ex_valid_i = 1'b0; mem_en_i = 1'b0;
    chk("rstbusy_req_after", 64'(dmem_req_o), 64'h0);
    chk("rstbusy_stall_after", 64'(stall_o), 64'h0);
    dmem_ack_i = 1'b1; dmem_rdata_i = 64'hFFFF_0000_FFFF_0000;
    tick();
    dmem_ack_i = 1'b0; dmem_rdata_i = 64'h0;
    chk("rstbusy_late_ack_wb", 64'(wb_valid_o), 64'h0);
    chk("rstbusy_late_ack_req", 64'(dmem_req_o), 64'h0);
    tick();
    alu_op(64'h0000_0000_0000_BEEF, 5'd3, 1'b1);
    tick();
    tick();

    chk("sb_empty", 64'(sb_q.size()), 64'h0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
